seq_divider: RTL and testbench
==============================

# seq_divider

Multi-cycle restoring divider for the ALU datapath. It accepts a 16-bit dividend and divisor on a start strobe and produces quotient and remainder one bit per clock using shift-and-subtract. It signals completion with a one-cycle done pulse. It sits beside the ALU adder and serves divide-class operations that cannot complete in a single cycle.

## Interface
- `WIDTH`, default 16: operand, quotient and remainder width; the design must work for any `WIDTH` ≥ 4.
- `cp2` input, 1 bit: core clock; all state changes on the rising edge.
- `ireset` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: request; accepted only when `busy`=0.
- `dividend` input, `WIDTH` bits: sampled on accepted `start`.
- `divisor` input, `WIDTH` bits: sampled on accepted `start`.
- `signed_op` input, 1 bit: two's-complement operation; ignored without `DIV_SIGNED_EN`.
- `quotient` output, `WIDTH` bits: result; held until next accepted `start`.
- `remainder` output, `WIDTH` bits: result; held until next accepted `start`.
- `busy` output, 1 bit: operation in progress.
- `done` output, 1 bit: one-cycle pulse when results become valid.
- `div_by_zero` output, 1 bit: divisor was 0; held with the results.
- `ovf` output, 1 bit: signed overflow (most-negative ÷ −1); held with the results; constant 0 without `DIV_SIGNED_EN`.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - An accepted `start` latches the operands and clears the step counter.
  - Divisor ≠ 0: go to CALC.
  - Divisor = 0: go straight to DONE with quotient all-ones, remainder = dividend, `div_by_zero`=1.
- CALC, one step per cycle:
  - Shifted partial remainder P = {R[WIDTH-1:0], Q[WIDTH-1]}, `WIDTH`+1 bits.
  - T = P − D, `WIDTH`+1 bits.
  - T ≥ 0: R=T, Q={Q[WIDTH-2:0],1}.
  - T < 0: R=P, Q={Q[WIDTH-2:0],0}.
  - After `WIDTH` steps, go to DONE.
- DONE: register the final results to the outputs, pulse `done`, return to IDLE.
- `start` while `busy`=1 is ignored; operands and FSM are unaffected.
- `start` in the cycle DONE is active is ignored, because `busy` is still 1.
- Outputs change only on the DONE transition; they are stable otherwise.
- Reset mid-operation: immediate return to IDLE and all outputs cleared; no `done` for the aborted operation.

## Timing
- Reset values: `quotient`=0, `remainder`=0, `busy`=0, `done`=0, `div_by_zero`=0, `ovf`=0.
- `start` accepted at edge 0. `busy`=1 from edge 0 through edge `WIDTH`+1.
- CALC occupies edges 1..`WIDTH`.
- `done`=1 and results valid after edge `WIDTH`+1 (17 for `WIDTH`=16); `busy` falls at the same edge.
- Divide by zero: `done` after edge 1.
- Throughput: a new `start` is accepted in the cycle after `done`.

## Configuration
- `DIV_SIGNED_EN` defined, when `signed_op`=1:
  - Operands are converted to magnitudes at latch time.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend, so results truncate toward zero.
  - Sign correction is applied on the DONE load; latency is unchanged.
  - Most-negative ÷ −1 gives quotient = most-negative, remainder = 0, `ovf`=1.
  - Signed divide by zero gives quotient all-ones, remainder = dividend.
- `DIV_SIGNED_EN` undefined: unsigned only; `signed_op` is unused; `ovf` is tied to 0.

## Structure
- Package `div_pkg`: FSM state enum `div_state_t` (IDLE, CALC, DONE) and the default width constant `DIV_WIDTH`=16.
- Sub-module `div_trial_sub`: combinational `WIDTH`+1-bit subtractor producing T and its sign bit, implemented as add with inverted B and carry-in 1.
- Top level: FSM, step counter of $clog2(`WIDTH`+1) bits, R/Q/D registers, sign-fix logic.

## Test plan
- 1000 ÷ 7, unsigned → `done` after edge 17, `quotient`=142, `remainder`=6, flags 0.
- 0xFFFF ÷ 1 → `quotient`=0xFFFF, `remainder`=0; then 5 ÷ 9 → `quotient`=0, `remainder`=5.
- 0x1234 ÷ 0 → `done` after edge 1, `quotient`=0xFFFF, `remainder`=0x1234, `div_by_zero`=1.
- Second `start` with different operands at edge 5 of a 1000 ÷ 7 → ignored; result still 142 r 6; exactly one `done` pulse.
- `ireset` asserted at edge 8 of an operation → all outputs 0 immediately, no `done`; a new 100 ÷ 10 then gives 10 r 0.
- With `DIV_SIGNED_EN`:
  - −7 ÷ 2 → `quotient`=0xFFFD, `remainder`=0xFFFF.
  - 0x8000 ÷ 0xFFFF → `quotient`=0x8000, `remainder`=0, `ovf`=1.

Source files
------------

// File: rtl/div_pkg.sv
// Shared FSM state type and default operand width for the sequential divider.
package div_pkg;
   localparam int DIV_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;
endpackage

// File: rtl/div_trial_sub.sv
// Trial subtraction for one restoring-divide step: diff = a - b, neg = sign of diff.
// Latency: combinational.
// Backpressure: none, pure datapath.
module div_trial_sub
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH:0] a,
   input  logic [WIDTH:0] b,
   output logic [WIDTH:0] diff,
   output logic           neg
);

   always_comb begin
      diff = a + ~b + {{WIDTH{1'b0}}, 1'b1};
      neg  = diff[WIDTH];
   end

endmodule

// File: rtl/seq_divider.sv
// Restoring shift-and-subtract divider, one quotient bit per clock (signed mode: DIV_SIGNED_EN).
// Latency: done WIDTH+1 edges after an accepted start, 1 edge on divide by zero.
// Backpressure: start is accepted only while busy is low; later strobes are dropped.
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             cp2,
   input  logic             ireset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             signed_op,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic             ovf
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   div_state_t       state;
   logic [CNT_W-1:0] step_cnt;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] d_q;
   logic             dbz_q;

   logic [WIDTH:0]   p_val;
   logic [WIDTH:0]   d_ext;
   logic [WIDTH:0]   t_val;
   logic             t_neg;
   logic             unused_t_msb;

   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   assign p_val = {r_q, q_q[WIDTH-1]};
   assign d_ext = {1'b0, d_q};

   div_trial_sub #(.WIDTH(WIDTH)) u_trial (
      .a    (p_val),
      .b    (d_ext),
      .diff (t_val),
      .neg  (t_neg)
   );

   // A negative trial means P < D, so the low WIDTH bits carry everything needed.
   assign unused_t_msb = t_val[WIDTH];

`ifdef DIV_SIGNED_EN
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic a_neg;
   logic b_neg;
   logic ovf_hit;
   logic q_neg_q;
   logic r_neg_q;
   logic ovf_pend;
   logic ovf_q;

   assign a_neg   = signed_op & dividend[WIDTH-1];
   assign b_neg   = signed_op & divisor[WIDTH-1];
   assign a_mag   = a_neg ? -dividend : dividend;
   assign b_mag   = b_neg ? -divisor : divisor;
   assign ovf_hit = signed_op && (dividend == MOST_NEG) && (divisor == '1);
   assign q_fix   = q_neg_q ? -q_q : q_q;
   assign r_fix   = r_neg_q ? -r_q : r_q;
   assign ovf     = ovf_q;

   // Divide by zero keeps the raw dividend and all-ones quotient, so no sign fix.
   always_ff @(posedge cp2 or negedge ireset) begin
      if (!ireset) begin
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         ovf_pend <= 1'b0;
         ovf_q    <= 1'b0;
      end else if (state == IDLE && start) begin
         q_neg_q  <= (a_neg ^ b_neg) && (divisor != '0);
         r_neg_q  <= a_neg && (divisor != '0);
         ovf_pend <= ovf_hit;
      end else if (state == DONE) begin
         ovf_q    <= ovf_pend;
      end
   end
`else
   logic unused_signed_op;

   assign a_mag            = dividend;
   assign b_mag            = divisor;
   assign q_fix            = q_q;
   assign r_fix            = r_q;
   assign ovf              = 1'b0;
   assign unused_signed_op = signed_op;
`endif

   always_ff @(posedge cp2 or negedge ireset) begin
      if (!ireset) begin
         state       <= IDLE;
         step_cnt    <= '0;
         r_q         <= '0;
         q_q         <= '0;
         d_q         <= '0;
         dbz_q       <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  step_cnt <= '0;
                  d_q      <= b_mag;
                  busy     <= 1'b1;
                  if (divisor == '0) begin
                     r_q   <= dividend;
                     q_q   <= '1;
                     dbz_q <= 1'b1;
                     state <= DONE;
                  end else begin
                     r_q   <= '0;
                     q_q   <= a_mag;
                     dbz_q <= 1'b0;
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               r_q      <= t_neg ? p_val[WIDTH-1:0] : t_val[WIDTH-1:0];
               q_q      <= {q_q[WIDTH-2:0], ~t_neg};
               step_cnt <= step_cnt + CNT_W'(1);
               if (step_cnt == LAST_STEP) begin
                  state <= DONE;
               end
            end
            DONE: begin
               quotient    <= q_fix;
               remainder   <= r_fix;
               div_by_zero <= dbz_q;
               done        <= 1'b1;
               busy        <= 1'b0;
               state       <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results queued at start, checked at done.
module tb_seq_divider;
   localparam int W = 16;

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
      logic         ovf;
   } exp_t;

   logic         cp2;
   logic         ireset;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         signed_op;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         busy;
   logic         done;
   logic         div_by_zero;
   logic         ovf;

   exp_t sb[$];
   int   total;
   int   bad;

   seq_divider #(.WIDTH(W)) dut (
      .cp2         (cp2),
      .ireset      (ireset),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .signed_op   (signed_op),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .ovf         (ovf)
   );

   initial begin
      cp2 = 1'b0;
      forever #5 cp2 = ~cp2;
   end

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      exp_t e;
      e.q   = '0;
      e.r   = '0;
      e.dbz = 1'b0;
      e.ovf = 1'b0;
      if (b == '0) begin
         e.q   = '1;
         e.r   = a;
         e.dbz = 1'b1;
      end
`ifdef DIV_SIGNED_EN
      else if (s) begin
         if (a == 16'h8000 && b == 16'hFFFF) begin
            e.q   = 16'h8000;
            e.r   = '0;
            e.ovf = 1'b1;
         end else begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
         end
      end
`endif
      else begin
         e.q = a / b;
         e.r = a % b;
         if (s) e.ovf = 1'b0;
      end
      return e;
   endfunction

   // Drives one start strobe; the edge it is sampled on is edge 0.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      @(negedge cp2);
      dividend  = a;
      divisor   = b;
      signed_op = s;
      start     = 1'b1;
      sb.push_back(model(a, b, s));
      @(posedge cp2);
      #1;
      start = 1'b0;
   endtask

   // Returns the edge number on which done was seen, 0 if it never came.
   task automatic wait_done(output int lat);
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge cp2);
         #1;
         if (done) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset;
      ireset = 1'b0;
      repeat (3) @(negedge cp2);
      total++;
      if ({quotient, remainder} !== '0) begin
         bad++;
         $display("FAIL reset_data got q=%h r=%h want 0 0", quotient, remainder);
      end
      total++;
      if ({busy, done, div_by_zero, ovf} !== 4'b0) begin
         bad++;
         $display("FAIL reset_flags got busy=%b done=%b dbz=%b ovf=%b want all 0",
                  busy, done, div_by_zero, ovf);
      end
      ireset = 1'b1;
   endtask

   task automatic test_unsigned;
      logic [W-1:0] ta[6] = '{16'd1000, 16'hFFFF, 16'd5, 16'hFFFF, 16'd0, 16'h8000};
      logic [W-1:0] tb[6] = '{16'd7, 16'd1, 16'd9, 16'hFFFF, 16'd3, 16'd3};
      logic [W-1:0] a, b;
      int lat;
      exp_t e;
      for (int i = 0; i < 12; i++) begin
         if (i < 6) begin
            a = ta[i];
            b = tb[i];
         end else begin
            a = W'($urandom_range(0, 65535));
            b = W'($urandom_range(1, (i % 2 == 0) ? 255 : 65535));
         end
         issue(a, b, 1'b0);
         total++;
         if (busy !== 1'b1) begin
            bad++;
            $display("FAIL unsigned_busy a=%h b=%h got=%b want=1", a, b, busy);
         end
         wait_done(lat);
         e = sb.pop_front();
         total++;
         if (lat !== W + 1) begin
            bad++;
            $display("FAIL unsigned_latency a=%h b=%h got=%0d want=%0d", a, b, lat, W + 1);
         end
         total++;
         if ({quotient, remainder, div_by_zero, ovf, busy} !== {e.q, e.r, e.dbz, e.ovf, 1'b0}) begin
            bad++;
            $display("FAIL unsigned_result a=%h b=%h got q=%h r=%h dbz=%b ovf=%b busy=%b want q=%h r=%h dbz=%b ovf=%b busy=0",
                     a, b, quotient, remainder, div_by_zero, ovf, busy, e.q, e.r, e.dbz, e.ovf);
         end
      end
   endtask

   task automatic test_div_zero;
      logic [W-1:0] ta[2] = '{16'h1234, 16'hFFF9};
      logic         ts[2] = '{1'b0, 1'b1};
      int lat;
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         issue(ta[i], '0, ts[i]);
         wait_done(lat);
         e = sb.pop_front();
         total++;
         if (lat !== 1) begin
            bad++;
            $display("FAIL dbz_latency a=%h got=%0d want=1", ta[i], lat);
         end
         total++;
         if ({quotient, remainder, div_by_zero, ovf} !== {e.q, e.r, e.dbz, e.ovf}) begin
            bad++;
            $display("FAIL dbz_result a=%h got q=%h r=%h dbz=%b ovf=%b want q=%h r=%h dbz=%b ovf=%b",
                     ta[i], quotient, remainder, div_by_zero, ovf, e.q, e.r, e.dbz, e.ovf);
         end
      end
   endtask

   task automatic test_ignore_start;
      int done_cnt = 0;
      int first_lat = 0;
      logic [W-1:0] cq = '0, cr = '0;
      exp_t e;
      issue(16'd1000, 16'd7, 1'b0);
      for (int i = 1; i <= 30; i++) begin
         @(posedge cp2);
         #1;
         if (done) begin
            done_cnt++;
            if (first_lat == 0) begin
               first_lat = i;
               cq = quotient;
               cr = remainder;
            end
         end
         if (i == 4) begin
            dividend = 16'h1234;
            divisor  = 16'd0;
            start    = 1'b1;
         end
         if (i == 16) begin
            dividend = 16'd99;
            divisor  = 16'd3;
            start    = 1'b1;
         end
         if (i == 5 || i == 17) start = 1'b0;
      end
      e = sb.pop_front();
      total++;
      if (done_cnt !== 1 || first_lat !== W + 1) begin
         bad++;
         $display("FAIL ignore_done got pulses=%0d first=%0d want pulses=1 first=%0d",
                  done_cnt, first_lat, W + 1);
      end
      total++;
      if ({cq, cr, busy} !== {e.q, e.r, 1'b0}) begin
         bad++;
         $display("FAIL ignore_result got q=%h r=%h busy=%b want q=%h r=%h busy=0",
                  cq, cr, busy, e.q, e.r);
      end
   endtask

   task automatic test_back_to_back;
      int lat;
      exp_t e1, e2;
      issue(16'd40000, 16'd123, 1'b0);
      wait_done(lat);
      e1 = sb.pop_front();
      issue(16'd77, 16'd5, 1'b0);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL b2b_accept got busy=%b want=1", busy);
      end
      repeat (8) @(posedge cp2);
      #1;
      total++;
      if ({quotient, remainder} !== {e1.q, e1.r}) begin
         bad++;
         $display("FAIL b2b_hold got q=%h r=%h want q=%h r=%h", quotient, remainder, e1.q, e1.r);
      end
      wait_done(lat);
      e2 = sb.pop_front();
      total++;
      if (lat !== W + 1 - 8 || {quotient, remainder} !== {e2.q, e2.r}) begin
         bad++;
         $display("FAIL b2b_second got lat=%0d q=%h r=%h want lat=%0d q=%h r=%h",
                  lat, quotient, remainder, W + 1 - 8, e2.q, e2.r);
      end
   endtask

   task automatic test_reset_mid;
      int seen = 0;
      int lat;
      exp_t e;
      issue(16'd5000, 16'd3, 1'b0);
      void'(sb.pop_back());
      repeat (8) @(posedge cp2);
      #2;
      ireset = 1'b0;
      #1;
      total++;
      if ({quotient, remainder, busy, done, div_by_zero, ovf} !== '0) begin
         bad++;
         $display("FAIL midreset_clear got q=%h r=%h busy=%b done=%b dbz=%b ovf=%b want all 0",
                  quotient, remainder, busy, done, div_by_zero, ovf);
      end
      repeat (2) @(negedge cp2);
      ireset = 1'b1;
      for (int i = 0; i < 25; i++) begin
         @(posedge cp2);
         #1;
         if (done || busy) seen++;
      end
      total++;
      if (seen !== 0) begin
         bad++;
         $display("FAIL midreset_no_done got active_cycles=%0d want=0", seen);
      end
      issue(16'd100, 16'd10, 1'b0);
      wait_done(lat);
      e = sb.pop_front();
      total++;
      if (lat !== W + 1 || {quotient, remainder} !== {e.q, e.r}) begin
         bad++;
         $display("FAIL midreset_after got lat=%0d q=%h r=%h want lat=%0d q=%h r=%h",
                  lat, quotient, remainder, W + 1, e.q, e.r);
      end
   endtask

   task automatic test_signed;
      logic [W-1:0] ta[6] = '{16'hFFF9, 16'h8000, 16'd7, 16'hFFF9, 16'h8000, 16'hFFFF};
      logic [W-1:0] tb[6] = '{16'd2, 16'hFFFF, 16'hFFFE, 16'hFFFE, 16'd1, 16'h7FFF};
      int lat;
      exp_t e;
      for (int i = 0; i < 6; i++) begin
         issue(ta[i], tb[i], 1'b1);
         wait_done(lat);
         e = sb.pop_front();
         total++;
         if (lat !== W + 1) begin
            bad++;
            $display("FAIL signed_latency a=%h b=%h got=%0d want=%0d", ta[i], tb[i], lat, W + 1);
         end
         total++;
         if ({quotient, remainder, div_by_zero, ovf} !== {e.q, e.r, e.dbz, e.ovf}) begin
            bad++;
            $display("FAIL signed_result a=%h b=%h got q=%h r=%h dbz=%b ovf=%b want q=%h r=%h dbz=%b ovf=%b",
                     ta[i], tb[i], quotient, remainder, div_by_zero, ovf, e.q, e.r, e.dbz, e.ovf);
         end
      end
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      ireset    = 1'b0;
      start     = 1'b0;
      dividend  = '0;
      divisor   = '0;
      signed_op = 1'b0;
      test_reset();
      test_unsigned();
      test_div_zero();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      test_signed();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
